enigma_rotor_stage: RTL and testbench

Parametrised, pipelined Enigma rotor offset stage: converts a one-hot letter to an index, adds or subtracts the rotor's registered position modulo N, and returns a one-hot letter. Unlike the earlier combinational offset block, it holds its own rotor position, steps on request, produces a carry for the next rotor, and supports forward and reverse traversal. Instances chain right-to-left in the rotor bank; step_out of one stage feeds step_in of the next.

---
 rtl/enigma_pkg.sv | 34 +++
 rtl/enigma_rotor_stage_if.sv | 29 ++
 rtl/enigma_onehot2idx.sv | 30 +++
 rtl/enigma_rotor_stage.sv | 116 +++++++++++
 tb/tb_enigma_rotor_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// Shared types, defaults and modular helpers for the Enigma rotor stage.
// Optional feature macro: ENIGMA_DOUBLE_STEP_EN (middle-rotor double step).
package enigma_pkg;

    localparam int N_DEF     = 26;
    localparam int W_DEF     = 6;
    localparam int NOTCH_DEF = 25;

    // Index width for the largest alphabet (64), plus one carry/sign bit.
    localparam int IDX_W = 6;
    localparam int EXT_W = IDX_W + 1;

    typedef logic [EXT_W-1:0] ext_t;

    function automatic ext_t mod_add(input ext_t a, input ext_t b, input ext_t n);
        ext_t s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

    // Top bit of the difference acts as the sign since both operands are < 64.
    function automatic ext_t mod_sub(input ext_t a, input ext_t b, input ext_t n);
        ext_t d;
        d = a - b;
        if (d[EXT_W-1]) begin
            d = d + n;
        end
        return d;
    endfunction

endpackage

// File: rtl/enigma_rotor_stage_if.sv
// Letter bus of the rotor stage: one-hot letter in, one-hot letter out.
interface enigma_rotor_stage_if #(
    parameter int N = 26
);
    logic         in_valid;
    logic [N-1:0] in_onehot;
    logic         dir;
    logic         out_valid;
    logic [N-1:0] out_onehot;
    logic         out_err;

    modport master (
        output in_valid,
        output in_onehot,
        output dir,
        input  out_valid,
        input  out_onehot,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_onehot,
        input  dir,
        output out_valid,
        output out_onehot,
        output out_err
    );
endinterface

// File: rtl/enigma_onehot2idx.sv
// One-hot to binary index; err flags zero or multiple set bits.
module enigma_onehot2idx #(
    parameter int N = 26,
    parameter int W = 6
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         err
);

    logic seen;
    logic multi;

    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = idx | W'(i);
            end
        end
        err = !seen || multi;
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// Pipelined Enigma rotor offset stage with its own stepping position register.
// Define ENIGMA_DOUBLE_STEP_EN to let a rotor on its notch step itself on key.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int NOTCH = NOTCH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [W-1:0]         load_pos,
    input  logic                 key,
    input  logic                 step_in,
    output logic                 step_out,
    output logic [W-1:0]         pos,
    enigma_rotor_stage_if.slave  bus
);

    localparam logic [W-1:0] NOTCH_P = W'(NOTCH);
    localparam logic [W-1:0] LAST_P  = W'(N - 1);
    localparam logic [W:0]   N_P     = (W + 1)'(N);
    localparam ext_t         N_EXT   = EXT_W'(N);
    localparam logic [N-1:0] ONE     = {{(N - 1){1'b0}}, 1'b1};

    logic advance;
    logic at_notch;

    assign at_notch = (pos == NOTCH_P);

`ifdef ENIGMA_DOUBLE_STEP_EN
    assign advance = step_in || (key && at_notch);
`else
    logic unused_key;
    assign unused_key = key;
    assign advance    = step_in;
`endif

    assign step_out = advance && at_notch && !load;

    // Out-of-range loads are dropped; load wins over a step.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= '0;
        end else if (load) begin
            if ({1'b0, load_pos} < N_P) begin
                pos <= load_pos;
            end
        end else if (advance) begin
            pos <= (pos == LAST_P) ? '0 : pos + 1'b1;
        end
    end

    logic [W-1:0] idx0;
    logic         err0;

    enigma_onehot2idx #(
        .N (N),
        .W (W)
    ) u_o2i (
        .onehot (bus.in_onehot),
        .idx    (idx0),
        .err    (err0)
    );

    logic         valid1;
    logic         dir1;
    logic         err1;
    logic [W-1:0] idx1;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid1 <= 1'b0;
            dir1   <= 1'b0;
            err1   <= 1'b0;
            idx1   <= '0;
        end else begin
            valid1 <= bus.in_valid;
            dir1   <= bus.dir;
            err1   <= err0;
            idx1   <= idx0;
        end
    end

    // pos here already reflects any step taken on the stage-1 edge.
    ext_t         res_ext;
    logic [W-1:0] res;

    always_comb begin
        if (dir1) begin
            res_ext = mod_sub(EXT_W'(idx1), EXT_W'(pos), N_EXT);
        end else begin
            res_ext = mod_add(EXT_W'(idx1), EXT_W'(pos), N_EXT);
        end
        res = W'(res_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_onehot <= '0;
            bus.out_err    <= 1'b0;
        end else begin
            bus.out_valid <= valid1;
            if (valid1 && !err1) begin
                bus.out_onehot <= ONE << res;
                bus.out_err    <= 1'b0;
            end else begin
                bus.out_onehot <= '0;
                bus.out_err    <= valid1 && err1;
            end
        end
    end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for enigma_rotor_stage (N=26, W=6, NOTCH=25).
module tb_enigma_rotor_stage;

    localparam int N = 26;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_pos;
    logic         key;
    logic         step_in;
    logic         step_out;
    logic [W-1:0] pos;

    int tests = 0;
    int fails = 0;

    enigma_rotor_stage_if #(.N(N)) bus ();

    enigma_rotor_stage #(
        .N     (N),
        .W     (W),
        .NOTCH (25)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_pos (load_pos),
        .key      (key),
        .step_in  (step_in),
        .step_out (step_out),
        .pos      (pos),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_load(input logic [W-1:0] p);
        load     = 1'b1;
        load_pos = p;
        tick();
        load     = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] v, input logic d);
        bus.in_valid  = 1'b1;
        bus.in_onehot = v;
        bus.dir       = d;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_onehot = '0;
        bus.dir       = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        load          = 1'b0;
        load_pos      = '0;
        key           = 1'b0;
        step_in       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_onehot = '0;
        bus.dir       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_pos", pos, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_onehot", bus.out_onehot, 0);
        check("rst_err", bus.out_err, 0);

        // Identity at pos 0, with latency check
        bus.in_valid  = 1'b1;
        bus.in_onehot = oh(3);
        bus.dir       = 1'b0;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_onehot = '0;
        check("lat1_valid", bus.out_valid, 0);
        tick();
        check("id_valid", bus.out_valid, 1);
        check("id_onehot", bus.out_onehot, oh(3));
        check("id_err", bus.out_err, 0);
        check("id_pos", pos, 0);

        // Back-to-back: fwd 22+5 wraps to 1, rev 2-5 wraps to 23
        do_load(5);
        check("load5", pos, 5);
        bus.in_valid  = 1'b1;
        bus.in_onehot = oh(22);
        bus.dir       = 1'b0;
        tick();
        bus.in_onehot = oh(2);
        bus.dir       = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_onehot = '0;
        bus.dir       = 1'b0;
        check("fwd_wrap", bus.out_onehot, oh(1));
        check("fwd_valid", bus.out_valid, 1);
        tick();
        check("rev_wrap", bus.out_onehot, oh(23));
        check("rev_valid", bus.out_valid, 1);
        tick();
        check("b2b_idle", bus.out_valid, 0);

        // Carry on wrap step
        do_load(25);
        step_in = 1'b1;
        #1;
        check("notch_carry", step_out, 1);
        tick();
        step_in = 1'b0;
        check("wrap_pos", pos, 0);
        step_in = 1'b1;
        #1;
        check("no_carry", step_out, 0);
        tick();
        step_in = 1'b0;
        check("step_pos", pos, 1);

        // Load beats step and suppresses carry
        do_load(25);
        load     = 1'b1;
        load_pos = 7;
        step_in  = 1'b1;
        #1;
        check("load_nocarry", step_out, 0);
        tick();
        load    = 1'b0;
        step_in = 1'b0;
        check("load_prio", pos, 7);

        // Out-of-range load ignored
        do_load(30);
        check("load_oor", pos, 7);

        // Step on the stage-1 edge is seen by stage 2: 3 + 8 = 11
        step_in = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_onehot = oh(3);
        bus.dir       = 1'b0;
        tick();
        step_in       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_onehot = '0;
        tick();
        check("step_first", bus.out_onehot, oh(11));
        check("step_pos8", pos, 8);

        // Load together with a letter: stage 2 uses 20; 10 - 20 = 16
        load          = 1'b1;
        load_pos      = 20;
        bus.in_valid  = 1'b1;
        bus.in_onehot = oh(10);
        bus.dir       = 1'b1;
        tick();
        load          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_onehot = '0;
        bus.dir       = 1'b0;
        tick();
        check("load_letter", bus.out_onehot, oh(16));

        // Malformed letters
        send('0, 1'b0);
        check("zero_err", bus.out_err, 1);
        check("zero_onehot", bus.out_onehot, 0);
        check("zero_valid", bus.out_valid, 1);
        send(26'h3, 1'b0);
        check("multi_err", bus.out_err, 1);
        check("multi_onehot", bus.out_onehot, 0);
        send(oh(25), 1'b0);
        check("last_fwd", bus.out_onehot, oh(19));
        check("last_err", bus.out_err, 0);

        // Key alone on the notch
        do_load(25);
        key = 1'b1;
        #1;
`ifdef ENIGMA_DOUBLE_STEP_EN
        check("dbl_carry", step_out, 1);
`else
        check("dbl_carry", step_out, 0);
`endif
        tick();
        key = 1'b0;
`ifdef ENIGMA_DOUBLE_STEP_EN
        check("dbl_pos", pos, 0);
`else
        check("dbl_pos", pos, 25);
`endif

        // Reset drops a letter sitting in stage 1
        do_load(4);
        bus.in_valid  = 1'b1;
        bus.in_onehot = oh(6);
        tick();
        bus.in_valid  = 1'b0;
        bus.in_onehot = '0;
        reset         = 1'b1;
        tick();
        check("rst_fly_valid", bus.out_valid, 0);
        check("rst_fly_pos", pos, 0);
        reset = 1'b0;
        tick();
        check("rst_fly_valid2", bus.out_valid, 0);
        check("rst_fly_onehot", bus.out_onehot, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
